// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state encoding and queue entry type for instruction fetch
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;
    localparam logic [0:0]  ST_BOOT  = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;
    localparam int          ENTRY_W  = 64 + 32;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_sel(input logic [63:0] beat, input logic hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: instruction master bus between fetch stage and memory controller
interface inst_fetch_queue_if;

    logic        bus_wait;
    logic [63:0] HRDATA;
    logic        HTRANS;
    logic [63:0] HADDR;

    modport master (input bus_wait, HRDATA, output HTRANS, HADDR);
    modport slave  (output bus_wait, HRDATA, input HTRANS, HADDR);

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, flush has priority over push/pop
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    // entry storage, written at the tail
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap modulo DEPTH; count tracks occupancy
    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: prefetching instruction fetch stage with redirect flush
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                      CLK,
    input  logic                      reset,
    inst_fetch_queue_if.master        bus,
    input  logic                      redirect_en,
    input  logic [63:0]               redirect_pc,
    input  logic                      dec_ready,
    output logic [31:0]               inst,
    output logic [63:0]               inst_pc,
    output logic                      inst_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [0:0]    state;
    logic [63:0]   fetch_pc;
    logic [63:0]   req_pc;
    logic          pending;
    logic          stale;
    logic          issue;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    fetch_entry_t  din;
    fetch_entry_t  dout;

    // in-flight beats reserve a slot, so count+pending bounds issue
    assign issue      = (state == ST_RUN) && !redirect_en && !full && (32'(count) + 32'(pending) < DEPTH);
    assign accept     = issue && !bus.bus_wait;
    assign bus.HTRANS = issue;
    assign bus.HADDR  = {fetch_pc[63:3], 3'b000};
    assign push       = pending && !stale && !redirect_en;
    assign pop        = inst_valid && dec_ready && !redirect_en;
    assign din        = '{pc: req_pc, inst: word_sel(bus.HRDATA, req_pc[2])};

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_en),
        .din   (din),
        .dout  (dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // decode view of the queue head, NOP/0 when empty
    always_comb begin
        inst_valid = !empty;
        inst       = empty ? NOP_INST : dout.inst;
        inst_pc    = empty ? 64'h0 : dout.pc;
    end

    // BOOT/RUN state, fetch PC, and in-flight tracking with redirect tagging
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= ST_BOOT;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            pending  <= 1'b0;
            stale    <= 1'b0;
        end else begin
            state    <= ST_RUN;
            pending  <= accept;
            stale    <= redirect_en;
            req_pc   <= accept ? fetch_pc : req_pc;
            fetch_pc <= redirect_en ? (redirect_pc & ~64'h3) : accept ? fetch_pc + 64'd4 : fetch_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for the instruction fetch queue
module tb_inst_fetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK;
    logic        reset;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        dec_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_valid;
    int          vectors;
    int          miscompares;

    inst_fetch_queue_if bus();

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .bus         (bus),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .dec_ready   (dec_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // instruction image: word @0 fixed, everything else derived from the PC
    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        if (pc[63:3] == 61'd0) return pc[2] ? 32'h00500113 : 32'h00100093;
        return pc[31:0] ^ pc[63:32] ^ 32'h5A5A0003;
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] addr);
        logic [63:0] a;
        a = {addr[63:3], 3'b000};
        return {inst_of(a + 64'd4), inst_of(a)};
    endfunction

    // memory responder: data valid the cycle after an accepted request
    always @(posedge CLK) begin
        if (bus.HTRANS && !bus.bus_wait) bus.HRDATA <= mem_word(bus.HADDR);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic rst_seq();
        reset = 1'b1;
        go(2);
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 64'h0;
        dec_ready   = 1'b1;
        bus.bus_wait = 1'b0;

        // basic fetch: reset values, latency, word select
        rst_seq();
        @(negedge CLK);
        chk("rst_htrans", 64'(bus.HTRANS), 64'd0);
        chk("rst_haddr", bus.HADDR, 64'h0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'(NOP));
        chk("rst_pc", inst_pc, 64'h0);
        go(1); @(negedge CLK);
        chk("b_c1_htrans", 64'(bus.HTRANS), 64'd1);
        chk("b_c1_haddr", bus.HADDR, 64'h0);
        go(1); @(negedge CLK);
        chk("b_c2_valid", 64'(inst_valid), 64'd0);
        chk("b_c2_inst", 64'(inst), 64'(NOP));
        go(1); @(negedge CLK);
        chk("b_c3_valid", 64'(inst_valid), 64'd1);
        chk("b_c3_inst", 64'(inst), 64'h00100093);
        chk("b_c3_pc", inst_pc, 64'h0);
        go(1); @(negedge CLK);
        chk("b_c4_inst", 64'(inst), 64'h00500113);
        chk("b_c4_pc", inst_pc, 64'h4);
        go(1); @(negedge CLK);
        chk("b_c5_inst", 64'(inst), 64'(inst_of(64'h8)));

        // fill to DEPTH with decode stalled, then drain in order
        dec_ready = 1'b0;
        rst_seq();
        go(1); @(negedge CLK);
        chk("f_c1_htrans", 64'(bus.HTRANS), 64'd1);
        go(1); @(negedge CLK);
        chk("f_c2_htrans", 64'(bus.HTRANS), 64'd1);
        go(1); @(negedge CLK);
        chk("f_c3_htrans", 64'(bus.HTRANS), 64'd1);
        chk("f_c3_haddr", bus.HADDR, 64'h8);
        go(1); @(negedge CLK);
        chk("f_c4_htrans", 64'(bus.HTRANS), 64'd1);
        go(1); @(negedge CLK);
        chk("f_c5_htrans", 64'(bus.HTRANS), 64'd0);
        go(1);
        dec_ready = 1'b1;
        @(negedge CLK);
        chk("f_c6_htrans", 64'(bus.HTRANS), 64'd0);
        chk("f_c6_pc", inst_pc, 64'h0);
        go(1); @(negedge CLK);
        chk("f_c7_htrans", 64'(bus.HTRANS), 64'd1);
        chk("f_c7_haddr", bus.HADDR, 64'h10);
        chk("f_c7_pc", inst_pc, 64'h4);
        go(1); @(negedge CLK);
        chk("f_c8_pc", inst_pc, 64'h8);
        go(1); @(negedge CLK);
        chk("f_c9_pc", inst_pc, 64'hC);
        go(1); @(negedge CLK);
        chk("f_c10_pc", inst_pc, 64'h10);
        chk("f_c10_inst", 64'(inst), 64'(inst_of(64'h10)));

        // bus_wait stretches the first request without duplicating it
        bus.bus_wait = 1'b1;
        rst_seq();
        for (int c = 1; c <= 3; c++) begin
            go(1); @(negedge CLK);
            chk($sformatf("w_c%0d_htrans", c), 64'(bus.HTRANS), 64'd1);
            chk($sformatf("w_c%0d_haddr", c), bus.HADDR, 64'h0);
        end
        go(1);
        bus.bus_wait = 1'b0;
        @(negedge CLK);
        chk("w_c4_htrans", 64'(bus.HTRANS), 64'd1);
        go(1); @(negedge CLK);
        chk("w_c5_valid", 64'(inst_valid), 64'd0);
        go(1); @(negedge CLK);
        chk("w_c6_valid", 64'(inst_valid), 64'd1);
        chk("w_c6_pc", inst_pc, 64'h0);
        go(1); @(negedge CLK);
        chk("w_c7_pc", inst_pc, 64'h4);
        chk("w_c7_inst", 64'(inst), 64'h00500113);

        // redirect during steady fetch discards in-flight beats
        rst_seq();
        go(9); @(negedge CLK);
        chk("r_c9_pc", inst_pc, 64'h18);
        go(1);
        redirect_en = 1'b1;
        redirect_pc = 64'h103;
        @(negedge CLK);
        chk("r_c10_htrans", 64'(bus.HTRANS), 64'd0);
        go(1);
        redirect_en = 1'b0;
        @(negedge CLK);
        chk("r_c11_htrans", 64'(bus.HTRANS), 64'd1);
        chk("r_c11_haddr", bus.HADDR, 64'h100);
        chk("r_c11_valid", 64'(inst_valid), 64'd0);
        go(1); @(negedge CLK);
        chk("r_c12_valid", 64'(inst_valid), 64'd0);
        go(1); @(negedge CLK);
        chk("r_c13_valid", 64'(inst_valid), 64'd1);
        chk("r_c13_pc", inst_pc, 64'h100);
        chk("r_c13_inst", 64'(inst), 64'(inst_of(64'h100)));
        go(1); @(negedge CLK);
        chk("r_c14_pc", inst_pc, 64'h104);

        // redirect in BOOT to the top of the address space, PC wraps to 0
        rst_seq();
        redirect_en = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge CLK);
        chk("p_c0_htrans", 64'(bus.HTRANS), 64'd0);
        go(1);
        redirect_en = 1'b0;
        @(negedge CLK);
        chk("p_c1_htrans", 64'(bus.HTRANS), 64'd1);
        chk("p_c1_haddr", bus.HADDR, 64'hFFFF_FFFF_FFFF_FFF8);
        go(1); @(negedge CLK);
        chk("p_c2_haddr", bus.HADDR, 64'h0);
        go(1); @(negedge CLK);
        chk("p_c3_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("p_c3_inst", 64'(inst), 64'(inst_of(64'hFFFF_FFFF_FFFF_FFFC)));
        go(1); @(negedge CLK);
        chk("p_c4_pc", inst_pc, 64'h0);
        chk("p_c4_inst", 64'(inst), 64'h00100093);

        // reset with 3 entries queued and one beat in flight
        dec_ready = 1'b0;
        rst_seq();
        go(5); @(negedge CLK);
        chk("m_c5_htrans", 64'(bus.HTRANS), 64'd0);
        chk("m_c5_valid", 64'(inst_valid), 64'd1);
        reset = 1'b1;
        go(1); @(negedge CLK);
        chk("m_rst_valid", 64'(inst_valid), 64'd0);
        chk("m_rst_inst", 64'(inst), 64'(NOP));
        chk("m_rst_htrans", 64'(bus.HTRANS), 64'd0);
        chk("m_rst_haddr", bus.HADDR, 64'h0);
        reset = 1'b0;
        dec_ready = 1'b1;
        go(1); @(negedge CLK);
        chk("m_c1_htrans", 64'(bus.HTRANS), 64'd1);
        chk("m_c1_valid", 64'(inst_valid), 64'd0);
        go(1); @(negedge CLK);
        chk("m_c2_valid", 64'(inst_valid), 64'd0);
        go(1); @(negedge CLK);
        chk("m_c3_pc", inst_pc, 64'h0);
        chk("m_c3_inst", 64'(inst), 64'h00100093);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
